// File: rtl/ay_array_pkg.sv
// ay_array_pkg: definitions shared by the AY chip array and its mixer.
//   - stereo_mode encodings (mono / ABC / ACB / mono alias)
//   - mixer FSM state enum
//   - chip-select address prefix used by the array's select latch
//   - route(): per-channel left/right routing for a stereo mode
package ay_array_pkg;

  typedef enum logic [1:0] {
    MODE_MONO  = 2'd0,
    MODE_ABC   = 2'd1,
    MODE_ACB   = 2'd2,
    MODE_MONO3 = 2'd3
  } stereo_mode_e;

  typedef enum logic [1:0] {
    MIX_IDLE = 2'd0,
    MIX_ACC  = 2'd1,
    MIX_DONE = 2'd2
  } mix_state_e;

  // Address-latch values 0xFC..0xFF carry this prefix and pick a chip.
  localparam logic [5:0] SEL_PREFIX = 6'b111111;

  // Returns {to_left, to_right} for channel ch (0=A, 1=B, 2=C).
  function automatic logic [1:0] route(input logic [1:0] mode, input logic [1:0] ch);
    logic [1:0] lr;
    lr = 2'b11;
    case (mode)
      MODE_ABC: lr = (ch == 2'd0) ? 2'b10 : (ch == 2'd1) ? 2'b11 : 2'b01;
      MODE_ACB: lr = (ch == 2'd0) ? 2'b10 : (ch == 2'd1) ? 2'b01 : 2'b11;
      default:  lr = 2'b11;
    endcase
    return lr;
  endfunction

endpackage

// File: rtl/ay_3_8192.sv
// ay_3_8192: simplified AY-3-8912-style PSG register model.
// Bus decode (bc2=1): bdir/bc1 = 11 latch address, 10 write, 01 read.
// Only reacts to the bus while a8_i is high. The channel levels are the
// raw amplitude registers R8/R9/R10, sampled on each ce_i; no tone,
// noise or envelope generation is modelled.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ce_i               PSG clock enable (level update)
//   bdir_i/bc1_i/bc2_i bus control, a8_i chip select
//   din_i              bus write data
//   port_a_i/port_a_o  I/O port A (reads of R14 return port_a_i)
//   dout_o/oe_o        read data and read-valid
//   ch_a_o/ch_b_o/ch_c_o channel levels
module ay_3_8192 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_i,
  input  logic       bdir_i,
  input  logic       bc1_i,
  input  logic       bc2_i,
  input  logic       a8_i,
  input  logic [7:0] din_i,
  input  logic [7:0] port_a_i,
  output logic [7:0] dout_o,
  output logic       oe_o,
  output logic [7:0] port_a_o,
  output logic [7:0] ch_a_o,
  output logic [7:0] ch_b_o,
  output logic [7:0] ch_c_o
);
  logic [7:0] regs_q [16];
  logic [3:0] addr_q;
  logic       bus_act, do_latch, do_write, do_read;

  assign bus_act  = a8_i & bc2_i;
  assign do_latch = bus_act & bdir_i & bc1_i;
  assign do_write = bus_act & bdir_i & ~bc1_i;
  assign do_read  = bus_act & ~bdir_i & bc1_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 4'd0;
      ch_a_o <= 8'd0;
      ch_b_o <= 8'd0;
      ch_c_o <= 8'd0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'd0;
    end else begin
      // Chip address lives in the low nibble; other high nibbles are ignored.
      if (do_latch && din_i[7:4] == 4'd0) addr_q <= din_i[3:0];
      if (do_write) regs_q[addr_q] <= din_i;
      if (ce_i) begin
        ch_a_o <= regs_q[8];
        ch_b_o <= regs_q[9];
        ch_c_o <= regs_q[10];
      end
    end
  end

  assign dout_o   = (addr_q == 4'd14) ? port_a_i : regs_q[addr_q];
  assign oe_o     = do_read;
  assign port_a_o = regs_q[14];

endmodule

// File: rtl/ay_mix_seq.sv
// ay_mix_seq: sequential stereo mixer. On start_i in IDLE it walks all
// 3*NUM_AY channels, one per cycle, accumulating into left/right, then
// registers the sums and pulses valid_o (3*NUM_AY+1 cycles after start).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start_i       begin a pass (ignored unless IDLE)
//   mode_i        stereo mode, latched at pass start
//   en_i          per-chip enable; disabled chips add 0
//   ch_raw_i      per-chip {A,B,C} levels, chip k at [24k+23:24k]
//   left_o/right_o mixed samples, valid_o one-cycle update strobe
module ay_mix_seq
  import ay_array_pkg::*;
#(
  parameter int NUM_AY = 2,
  parameter int MIX_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [NUM_AY-1:0]     en_i,
  input  logic [24*NUM_AY-1:0]  ch_raw_i,
  output logic [MIX_W-1:0]      left_o,
  output logic [MIX_W-1:0]      right_o,
  output logic                  valid_o
);
  localparam int CHIP_W = (NUM_AY > 1) ? $clog2(NUM_AY) : 1;

  mix_state_e        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CHIP_W-1:0] chip_q, chip_d;
  logic [1:0]        ch_q, ch_d;
  logic [MIX_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [MIX_W-1:0]  left_d, right_d;
  logic              valid_d;
  logic [7:0]        level;
  logic [1:0]        lr;
  int                base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MIX_IDLE;
      mode_q  <= 2'd0;
      chip_q  <= '0;
      ch_q    <= 2'd0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      left_o  <= '0;
      right_o <= '0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      chip_q  <= chip_d;
      ch_q    <= ch_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      left_o  <= left_d;
      right_o <= right_d;
      valid_o <= valid_d;
    end
  end

  // Channel idx = 3*chip + ch; A sits in the top byte of each chip slot.
  always_comb begin
    base  = 24 * int'(chip_q) + 16 - 8 * int'(ch_q);
    level = en_i[chip_q] ? ch_raw_i[base +: 8] : 8'd0;
    lr    = route(mode_q, ch_q);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    chip_d  = chip_q;
    ch_d    = ch_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    left_d  = left_o;
    right_d = right_o;
    valid_d = 1'b0;
    case (state_q)
      MIX_IDLE: begin
        if (start_i) begin
          acc_l_d = '0;
          acc_r_d = '0;
          mode_d  = mode_i;
          chip_d  = '0;
          ch_d    = 2'd0;
          state_d = MIX_ACC;
        end
      end
      MIX_ACC: begin
        if (lr[1]) acc_l_d = acc_l_q + MIX_W'(level);
        if (lr[0]) acc_r_d = acc_r_q + MIX_W'(level);
        if (ch_q == 2'd2) begin
          ch_d = 2'd0;
          if (chip_q == CHIP_W'(NUM_AY - 1)) state_d = MIX_DONE;
          else chip_d = chip_q + 1'b1;
        end else begin
          ch_d = ch_q + 2'd1;
        end
      end
      MIX_DONE: begin
        left_d  = acc_l_q;
        right_d = acc_r_q;
        valid_d = 1'b1;
        state_d = MIX_IDLE;
      end
      default: state_d = MIX_IDLE;
    endcase
  end

endmodule

// File: rtl/ay_array.sv
// ay_array: array of NUM_AY AY chips behind one bus, with a chip-select
// latch (address values 0xFF..0xFC pick chips 0..3) and a stereo mixer.
// Optional feature macro: AY_ARRAY_MIDI_EN -- when defined, midi_out is
// the selected chip's port A bit 2; otherwise midi_out is tied to 1.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clk175en            PSG clock enable, also starts a mix pass
//   disable_ay          disables all chips
//   disable_turboay     disables chips 1..NUM_AY-1
//   bdir, bc1, din      AY bus
//   port_din            port A input to every chip
//   stereo_mode         0 mono, 1 ABC, 2 ACB, 3 mono
//   dout, oe, midi_out  selected chip's read data / valid / MIDI bit
//   ch_raw              per-chip {A,B,C} levels
//   left_out, right_out, mix_valid  mixer result and update strobe
module ay_array
  import ay_array_pkg::*;
#(
  parameter  int NUM_AY = 2,
  localparam int MIX_W  = 8 + $clog2(3 * NUM_AY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk175en,
  input  logic                 disable_ay,
  input  logic                 disable_turboay,
  input  logic                 bdir,
  input  logic                 bc1,
  input  logic [7:0]           din,
  input  logic [7:0]           port_din,
  input  logic [1:0]           stereo_mode,
  output logic [7:0]           dout,
  output logic                 oe,
  output logic                 midi_out,
  output logic [24*NUM_AY-1:0] ch_raw,
  output logic [MIX_W-1:0]     left_out,
  output logic [MIX_W-1:0]     right_out,
  output logic                 mix_valid
);
  localparam int SEL_W = (NUM_AY > 1) ? $clog2(NUM_AY) : 1;

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [1:0]        sel_k;
  logic              rst_n;
  logic [NUM_AY-1:0] en_mask;
  logic [NUM_AY-1:0] chip_oe;
  logic [7:0]        chip_dout [NUM_AY];
`ifdef AY_ARRAY_MIDI_EN
  logic [7:0]        port_a [NUM_AY];
`else
  logic [7:0]        port_a_unused [NUM_AY];
`endif

  assign rst_n = ~rst;

  // Select latch: only in-range chips, and only with every chip enabled.
  always_comb begin
    sel_d = sel_q;
    sel_k = ~din[1:0];
    if (bdir && bc1 && din[7:2] == SEL_PREFIX && !disable_ay && !disable_turboay
        && int'(sel_k) < NUM_AY)
      sel_d = sel_k[SEL_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= '0;
    else     sel_q <= sel_d;
  end

  for (genvar gi = 0; gi < NUM_AY; gi++) begin : g_chip
    assign en_mask[gi] = ~disable_ay & ((gi == 0) ? 1'b1 : ~disable_turboay);

    ay_3_8192 u_ay (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce_i     (clk175en & en_mask[gi]),
      .bdir_i   (bdir),
      .bc1_i    (bc1),
      .bc2_i    (1'b1),
      .a8_i     (sel_q == SEL_W'(gi)),
      .din_i    (din),
      .port_a_i (port_din),
      .dout_o   (chip_dout[gi]),
      .oe_o     (chip_oe[gi]),
`ifdef AY_ARRAY_MIDI_EN
      .port_a_o (port_a[gi]),
`else
      .port_a_o (port_a_unused[gi]),
`endif
      .ch_a_o   (ch_raw[24*gi+16 +: 8]),
      .ch_b_o   (ch_raw[24*gi+8 +: 8]),
      .ch_c_o   (ch_raw[24*gi +: 8])
    );
  end

  assign dout = chip_dout[sel_q];
  assign oe   = chip_oe[sel_q] & en_mask[sel_q];

`ifdef AY_ARRAY_MIDI_EN
  assign midi_out = port_a[sel_q][2];
`else
  assign midi_out = 1'b1;
`endif

  ay_mix_seq #(
    .NUM_AY (NUM_AY),
    .MIX_W  (MIX_W)
  ) u_mix (
    .clk      (clk),
    .rst      (rst),
    .start_i  (clk175en),
    .mode_i   (stereo_mode),
    .en_i     (en_mask),
    .ch_raw_i (ch_raw),
    .left_o   (left_out),
    .right_o  (right_out),
    .valid_o  (mix_valid)
  );

endmodule
